// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router: stores {header marker, byte} and tracks packet length.
// Latency: 1 cycle from an accepted read to data_out; a written byte becomes readable at the next edge.
// Backpressure: full/empty come from the pointer registers only; writes while full and reads while empty are dropped.
//
// Ports: clock, resetn (async, active low), soft_reset (sync clear), write_enb/lfd_state/data_in (write side),
//        read_enb/data_out (read side), full/empty (occupancy flags), packet_done (parity byte on data_out),
//        ovf_err (sticky misuse flag, present only when ROUTER_FIFO_OVF_ERR_EN is defined).
module router_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             packet_done
`ifdef ROUTER_FIFO_OVF_ERR_EN
    ,
    output logic             ovf_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] PTR_FULL_XOR = {1'b1, {AW{1'b0}}};

    logic [WIDTH:0]   mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             wr_acc, rd_acc;
    logic [WIDTH:0]   rd_entry;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = ((wr_ptr_q ^ rd_ptr_q) == PTR_FULL_XOR);

    // soft_reset wins over any same-cycle access.
    assign wr_acc   = write_enb && !full && !soft_reset;
    assign rd_acc   = read_enb && !empty && !soft_reset;
    assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        if (soft_reset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            dout_d   = '0;
            cnt_d    = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                dout_d   = rd_entry[WIDTH-1:0];
                if (rd_entry[WIDTH]) begin
                    // Header: payload length from bits 7:2, plus one for the parity byte.
                    // A header arriving mid-packet simply restarts the count.
                    cnt_d = rd_entry[7:2] + 6'd1;
                end else if (cnt_q != 6'd0) begin
                    cnt_d  = cnt_q - 6'd1;
                    // Registered so it lines up with the parity byte appearing on data_out.
                    done_d = (cnt_q == 6'd1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    // Storage is intentionally not reset; the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
        end
    end

    assign data_out    = dout_q;
    assign packet_done = done_q;

`ifdef ROUTER_FIFO_OVF_ERR_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (soft_reset) begin
            ovf_d = 1'b0;
        end else if ((write_enb && full) || (read_enb && empty)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_err = ovf_q;
`endif

endmodule

// File: tb/tb_router_fifo.sv
module tb_router_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic             soft_reset = 1'b0;
    logic             write_enb = 1'b0;
    logic             lfd_state = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             read_enb = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             packet_done;
`ifdef ROUTER_FIFO_OVF_ERR_EN
    logic             ovf_err;
`endif

    router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .packet_done(packet_done)
`ifdef ROUTER_FIFO_OVF_ERR_EN
        ,
        .ovf_err    (ovf_err)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] d;
        logic       pd;
    } exp_t;

    // Reference model: contents as a plain queue of {marker, byte}, a packet byte budget,
    // a sticky misuse flag, and the queue of expected read results for the monitor.
    logic [8:0] mq[$];
    int         m_left = 0;
    bit         m_ovf = 1'b0;
    exp_t       exp_q[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and advance the model to the state
    // the DUT should hold after the following rising edge.
    task automatic step(input bit we, input bit lfd, input logic [7:0] d, input bit re, input bit sr);
        bit   rd_ok, wr_ok;
        logic [8:0] e;
        exp_t x;
        @(negedge clock);
        write_enb  = we;
        lfd_state  = lfd;
        data_in    = d;
        read_enb   = re;
        soft_reset = sr;
        if (sr || !resetn) begin
            mq.delete();
            m_left = 0;
            m_ovf  = 1'b0;
        end else begin
            rd_ok = re && (mq.size() != 0);
            wr_ok = we && (mq.size() != DEPTH);
            if ((we && mq.size() == DEPTH) || (re && mq.size() == 0)) m_ovf = 1'b1;
            if (rd_ok) begin
                e    = mq.pop_front();
                x.d  = e[7:0];
                x.pd = 1'b0;
                if (e[8]) begin
                    m_left = ((int'(e[7:0]) >> 2) + 1) % 64;
                end else if (m_left > 0) begin
                    m_left--;
                    x.pd = (m_left == 0);
                end
                exp_q.push_back(x);
            end
            if (wr_ok) mq.push_back({lfd, d});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0);
    endtask

    task automatic wr(input bit lfd, input logic [7:0] d);
        step(1, lfd, d, 0, 0);
    endtask

    task automatic rd(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 1, 0);
    endtask

    task automatic send_packet(input logic [7:0] hdr, input logic [7:0] p0, input logic [7:0] p1,
                               input logic [7:0] p2, input logic [7:0] par);
        wr(1, hdr); wr(0, p0); wr(0, p1); wr(0, p2); wr(0, par);
    endtask

    // Monitor: whenever the DUT accepts a read it owes one output byte next cycle.
    logic [7:0] exp_dout = 8'h00;
    always @(posedge clock) begin
        bit   fired, clr;
        exp_t x;
        bit   pd_exp;
        fired  = resetn && !soft_reset && read_enb && !empty;
        clr    = !resetn || soft_reset;
        pd_exp = 1'b0;
        #1;
        if (clr) begin
            exp_dout = 8'h00;
            exp_q.delete();
        end else if (fired) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_read", 1, 0);
            end else begin
                x        = exp_q.pop_front();
                exp_dout = x.d;
                pd_exp   = x.pd;
            end
        end else if (exp_q.size() != 0) begin
            chk("missed_read", 0, 1);
            void'(exp_q.pop_front());
        end
        chk("data_out", int'(data_out), int'(exp_dout));
        chk("packet_done", int'(packet_done), int'(pd_exp));
        chk("empty", int'(empty), int'(mq.size() == 0));
        chk("full", int'(full), int'(mq.size() == DEPTH));
`ifdef ROUTER_FIFO_OVF_ERR_EN
        chk("ovf_err", int'(ovf_err), int'(m_ovf));
`endif
    end

    initial begin
        int occ;
        // Power-on reset.
        idle(3);
        @(negedge clock) resetn = 1'b1;
        idle(2);

        // Packet round trip, then a read while empty must hold 5E.
        send_packet(8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h5E);
        rd(5);
        rd(2);
        // Simultaneous write+read while empty: only the write lands.
        step(1, 0, 8'h77, 1, 0);
        rd(1);
        idle(1);

        // Full boundary: 17 writes, the last is dropped.
        for (int i = 0; i <= 16; i++) wr(0, 8'(i));
        rd(16);
        idle(1);

        // Simultaneous access at occupancy 8.
        for (int i = 0; i < 8; i++) wr(0, 8'(8'h40 + i));
        step(1, 0, 8'h48, 1, 0);
        rd(8);

        // Wrap-around at occupancy 3.
        for (int i = 0; i < 3; i++) wr(0, 8'(8'h80 + i));
        for (int i = 0; i < 40; i++) step(1, 0, 8'(8'h83 + i), 1, 0);
        rd(3);

        // Soft reset with 6 entries stored and 2 bytes of the packet still owed.
        wr(1, 8'h0D); wr(0, 8'hB1); wr(0, 8'hB2); wr(0, 8'hB3); wr(0, 8'hB4);
        wr(0, 8'hB5); wr(0, 8'hB6); wr(0, 8'hB7); wr(0, 8'hB8);
        rd(3);
        step(0, 0, 8'h00, 0, 1);
        idle(3);
        send_packet(8'h0D, 8'hC1, 8'hC2, 8'hC3, 8'h3C);
        rd(5);
        idle(1);

        // Asynchronous reset with 5 entries stored, mid-packet.
        send_packet(8'h11, 8'hD1, 8'hD2, 8'hD3, 8'hD4);
        rd(2);
        wr(0, 8'hD5); wr(0, 8'hD6);
        @(negedge clock) resetn = 1'b0;
        mq.delete(); m_left = 0; m_ovf = 1'b0;
        idle(2);
        @(negedge clock) resetn = 1'b1;
        idle(3);

        // Randomized traffic with varying fill bias, random headers and rare soft resets.
        for (int seg = 0; seg < 12; seg++) begin
            int wp, rp;
            wp = $urandom_range(20, 90);
            rp = $urandom_range(20, 90);
            for (int i = 0; i < 150; i++) begin
                bit we, re, lfd, sr;
                we  = ($urandom_range(99) < wp);
                re  = ($urandom_range(99) < rp);
                lfd = ($urandom_range(5) == 0);
                sr  = ($urandom_range(199) == 0);
                step(we, lfd, 8'($urandom), re, sr);
            end
        end
        occ = mq.size();
        rd(occ + 1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
